// File: rtl/iter_muldiv_pkg.sv
// iter_muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit: operation
//   mode encodings and the controller state encoding.
package iter_muldiv_pkg;

    // Operation select. Encoding 2'b11 is not listed and behaves as MODE_UMUL.
    localparam logic [1:0] MODE_UMUL = 2'b00;
    localparam logic [1:0] MODE_SMUL = 2'b01;
    localparam logic [1:0] MODE_UDIV = 2'b10;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   One iteration of the shared multiply/divide datapath, purely
//   combinational. The 2*WIDTH accumulator holds different things per mode:
//     multiply : {partial product high half, multiplier bits not yet used}
//     divide   : {partial remainder, dividend bits not yet used / quotient}
//   Ports:
//     is_div   - 1 selects a restoring-divide step, 0 a shift-add step
//     acc      - current accumulator
//     opnd     - multiplicand (multiply) or divisor (divide)
//     acc_next - accumulator after this iteration
module muldiv_step #(
    parameter int WIDTH = 4
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] diff_s;

    // Single shift-add or restoring-subtract iteration.
    always_comb begin
        // Shift-add: the carry out of the high half becomes the new MSB as
        // the whole accumulator shifts right, so no product bit is lost.
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        // Restoring divide: remainder shifted left with the next dividend
        // bit appended. The true difference always fits in WIDTH bits
        // because the remainder stays below the divisor, so the wrap of the
        // WIDTH-bit subtract is harmless. A zero divisor always "fits",
        // which yields quotient all-ones and remainder equal to the dividend.
        trial_s  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s   = trial_s[WIDTH-1:0] - opnd;
        acc_next = {(2*WIDTH){1'b0}};
        if (is_div) begin
            if (trial_s >= {1'b0, opnd}) begin
                acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv
//   Iterative unsigned/signed multiplier and unsigned divider, one bit per
//   clock, with a start/busy/finish handshake. The result is held until the
//   next operation completes.
//   Ports:
//     clk         - clock, rising edge
//     rst         - synchronous active-high reset
//     start       - request an operation (sampled only while idle)
//     mode        - 00 umul, 01 smul, 10 udiv, 11 same as 00
//     a, b        - multiplicand/multiplier or dividend/divisor
//     busy        - high from the cycle after acceptance through the DONE cycle
//     finish      - one-cycle pulse when res/div_by_zero become valid
//     res         - product, or {remainder, quotient} for divide
//     div_by_zero - set with finish for a divide by zero
module iter_muldiv
    import iter_muldiv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   res,
    output logic                 div_by_zero
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [RW-1:0]       acc_r;
    logic [WIDTH-1:0]    opnd_r;
    logic                is_div_r;
    logic                neg_r;
    logic                busy_r;
    logic                finish_r;
    logic [RW-1:0]       res_r;
    logic                dbz_r;

    logic [WIDTH-1:0]    a_neg_s;
    logic [WIDTH-1:0]    b_neg_s;
    logic [RW-1:0]       init_acc_s;
    logic [WIDTH-1:0]    init_opnd_s;
    logic                init_div_s;
    logic                init_neg_s;
    logic [RW-1:0]       step_acc_s;
    logic [RW-1:0]       final_s;
    logic                dbz_s;

    // Two's-complement negation of the raw operands, used as magnitudes.
    // The most-negative value negates to itself, which is already its
    // correct unsigned magnitude.
    always_comb begin
        a_neg_s = (~a) + WIDTH'(1);
        b_neg_s = (~b) + WIDTH'(1);
    end

    // Accumulator/operand image loaded when an operation is accepted.
    always_comb begin
        init_acc_s  = {RW{1'b0}};
        init_opnd_s = a;
        init_div_s  = 1'b0;
        init_neg_s  = 1'b0;
        case (mode)
            MODE_SMUL: begin
                init_acc_s  = {{WIDTH{1'b0}}, (b[WIDTH-1] ? b_neg_s : b)};
                init_opnd_s = a[WIDTH-1] ? a_neg_s : a;
                init_neg_s  = a[WIDTH-1] ^ b[WIDTH-1];
            end
            MODE_UDIV: begin
                init_acc_s  = {{WIDTH{1'b0}}, a};
                init_opnd_s = b;
                init_div_s  = 1'b1;
            end
            default: begin
                init_acc_s  = {{WIDTH{1'b0}}, b};
                init_opnd_s = a;
            end
        endcase
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .opnd     (opnd_r),
        .acc_next (step_acc_s)
    );

    // Sign fix-up of the final iteration's product and divide-by-zero flag.
    always_comb begin
        if (neg_r) begin
            final_s = (~step_acc_s) + RW'(1);
        end else begin
            final_s = step_acc_s;
        end
        dbz_s = is_div_r & (opnd_r == {WIDTH{1'b0}});
    end

    // Controller, iteration counter, datapath state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {RW{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            res_r    <= {RW{1'b0}};
            dbz_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    finish_r <= 1'b0;
                    if (start) begin
                        acc_r    <= init_acc_s;
                        opnd_r   <= init_opnd_s;
                        is_div_r <= init_div_s;
                        neg_r    <= init_neg_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        dbz_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= step_acc_s;
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        // Last iteration: publish the result straight from
                        // the step output so it is valid in the DONE cycle.
                        cnt_r    <= {CNT_W{1'b0}};
                        res_r    <= final_s;
                        dbz_r    <= dbz_s;
                        finish_r <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                        state_r  <= RUN;
                    end
                end
                DONE: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    cnt_r    <= {CNT_W{1'b0}};
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign finish      = finish_r;
    assign res         = res_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv
//   Directed self-checking bench for iter_muldiv at WIDTH=4 and WIDTH=8.
module tb_iter_muldiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, busy4, fin4, dbz4;
    logic [1:0] mode4;
    logic [3:0] a4, b4;
    logic [7:0] res4;
    logic       start8, busy8, fin8, dbz8;
    logic [1:0] mode8;
    logic [7:0] a8, b8;
    logic [15:0] res8;

    int n_cmp = 0;
    int n_bad = 0;

    iter_muldiv #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .finish(fin4), .res(res4), .div_by_zero(dbz4)
    );

    iter_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .finish(fin8), .res(res8), .div_by_zero(dbz8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one WIDTH=4 operation; returns result, flag and cycles to finish.
    task automatic op4(input logic [1:0] m, input logic [3:0] x, input logic [3:0] y,
                       output logic [7:0] r, output logic d, output int lat);
        @(negedge clk);
        start4 = 1'b1; mode4 = m; a4 = x; b4 = y;
        @(negedge clk);
        start4 = 1'b0; lat = 1;
        while (fin4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = res4; d = dbz4;
    endtask

    task automatic op8(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] r, output logic d, output int lat);
        @(negedge clk);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; lat = 1;
        while (fin8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = res8; d = dbz8;
    endtask

    logic [7:0]  r4;
    logic [15:0] r8;
    logic        d;
    int          lat;
    logic [6:0]  busy_h, fin_h;
    logic [3:0]  sa [0:17];
    logic [3:0]  sb [0:17];
    logic [1:0]  sm [0:17];
    logic [7:0]  exp_res [0:2];
    int          exp_cyc [0:2];
    int          n_fin;

    initial begin
        rst = 1'b1;
        start4 = 1'b0; mode4 = 2'b00; a4 = 4'd0; b4 = 4'd0;
        start8 = 1'b0; mode8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy4}, 32'd0);
        check_eq("rst_finish", {31'd0, fin4}, 32'd0);
        check_eq("rst_res", {24'd0, res4}, 32'd0);
        check_eq("rst_dbz", {31'd0, dbz4}, 32'd0);
        check_eq("rst_res8", {16'd0, res8}, 32'd0);

        // 1: unsigned multiply with exact busy/finish timing
        start4 = 1'b1; mode4 = 2'b00; a4 = 4'd13; b4 = 4'd11;
        @(negedge clk);
        start4 = 1'b0;
        busy_h = 7'd0; fin_h = 7'd0; r4 = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            busy_h[c] = busy4;
            fin_h[c]  = fin4;
            if (c == 5) r4 = res4;
            if (c < 6) @(negedge clk);
        end
        check_eq("umul_busy_window", {25'd0, busy_h}, 32'b0111110);
        check_eq("umul_finish_window", {25'd0, fin_h}, 32'b0100000);
        check_eq("umul_13x11", {24'd0, r4}, 32'h8F);

        // 2: signed multiply
        op4(2'b01, 4'b1000, 4'b1001, r4, d, lat);
        check_eq("smul_m8xm7", {24'd0, r4}, 32'h38);
        check_eq("smul_lat", lat, 32'd5);
        op4(2'b01, 4'b1101, 4'd5, r4, d, lat);
        check_eq("smul_m3x5", {24'd0, r4}, 32'hF1);
        op4(2'b01, 4'b1000, 4'b1000, r4, d, lat);
        check_eq("smul_m8xm8", {24'd0, r4}, 32'h40);

        // 3: unsigned divide and divide by zero
        op4(2'b10, 4'd13, 4'd4, r4, d, lat);
        check_eq("udiv_13_4", {24'd0, r4}, 32'h13);
        check_eq("udiv_13_4_dbz", {31'd0, d}, 32'd0);
        op4(2'b10, 4'd9, 4'd0, r4, d, lat);
        check_eq("udiv_9_0", {24'd0, r4}, 32'h9F);
        check_eq("udiv_9_0_dbz", {31'd0, d}, 32'd1);
        check_eq("udiv_9_0_lat", lat, 32'd5);
        repeat (3) @(negedge clk);
        check_eq("hold_res", {24'd0, res4}, 32'h9F);
        check_eq("hold_dbz", {31'd0, dbz4}, 32'd1);
        op4(2'b00, 4'd3, 4'd5, r4, d, lat);
        check_eq("umul_after_dbz", {24'd0, r4}, 32'h0F);
        check_eq("dbz_cleared", {31'd0, d}, 32'd0);

        // 4: start held high, operands changing every cycle
        for (int i = 0; i < 18; i++) begin
            sa[i] = 4'(i);
            sb[i] = 4'(15 - i);
            sm[i] = 2'b01;
        end
        sa[0]  = 4'd7;  sb[0]  = 4'd9; sm[0]  = 2'b00;
        sa[6]  = 4'd7;  sb[6]  = 4'd9; sm[6]  = 2'b11;
        sa[12] = 4'd14; sb[12] = 4'd3; sm[12] = 2'b10;
        exp_res[0] = 8'h3F; exp_res[1] = 8'h3F; exp_res[2] = 8'h24;
        exp_cyc[0] = 5;     exp_cyc[1] = 11;    exp_cyc[2] = 17;
        n_fin = 0;
        @(negedge clk);
        start4 = 1'b1; mode4 = sm[0]; a4 = sa[0]; b4 = sb[0];
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (fin4 === 1'b1) begin
                if (n_fin < 3) begin
                    check_eq("b2b_res", {24'd0, res4}, {24'd0, exp_res[n_fin]});
                    check_eq("b2b_cycle", k, exp_cyc[n_fin]);
                end
                n_fin++;
            end
            if (k == 17) begin
                start4 = 1'b0;
            end else begin
                mode4 = sm[k]; a4 = sa[k]; b4 = sb[k];
            end
        end
        check_eq("b2b_count", n_fin, 32'd3);
        @(negedge clk);

        // 5: reset in the second RUN cycle aborts the operation
        start4 = 1'b1; mode4 = 2'b00; a4 = 4'd5; b4 = 4'd5;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", {31'd0, busy4}, 32'd0);
        check_eq("abort_res", {24'd0, res4}, 32'd0);
        n_fin = 0;
        for (int k = 0; k < 6; k++) begin
            if (fin4 !== 1'b0) n_fin++;
            @(negedge clk);
        end
        check_eq("abort_no_finish", n_fin, 32'd0);
        op4(2'b00, 4'd2, 4'd3, r4, d, lat);
        check_eq("after_abort", {24'd0, r4}, 32'h06);

        // 6: WIDTH=8
        op8(2'b00, 8'd255, 8'd255, r8, d, lat);
        check_eq("w8_umul", {16'd0, r8}, 32'hFE01);
        check_eq("w8_lat", lat, 32'd9);
        op8(2'b10, 8'd200, 8'd7, r8, d, lat);
        check_eq("w8_udiv", {16'd0, r8}, 32'h041C);
        op8(2'b01, 8'h80, 8'h7F, r8, d, lat);
        check_eq("w8_smul", {16'd0, r8}, 32'hC080);
        op8(2'b10, 8'hA5, 8'h00, r8, d, lat);
        check_eq("w8_div0", {16'd0, r8}, 32'hA5FF);
        check_eq("w8_div0_dbz", {31'd0, d}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
Parametrised iterative arithmetic unit. It is the successor to the fixed 4-bit shift-add multiplier used in the lab display tops.
Performs unsigned multiply, signed multiply or unsigned divide, one bit per clock, under a start/busy/finish handshake.
The result is held stable for the seven-segment display path until the next operation completes.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16). Result width is 2*WIDTH.

Ports:
clk  input  1  system clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
mode  input  2  00 unsigned mul, 01 signed mul (two's complement), 10 unsigned div, 11 treated as 00
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high from the cycle after start is accepted through the DONE cycle
finish  output  1  one-cycle pulse; res and div_by_zero are valid from this cycle
res  output  2*WIDTH  product, or {remainder[WIDTH-1:0], quotient[WIDTH-1:0]} for divide
div_by_zero  output  1  set with finish when mode=10 and b=0

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, finish=0, res=0, div_by_zero=0, iteration counter=0.
- FSM states and transitions:
  - IDLE: if start=1, latch a, b and mode; clear div_by_zero; go to RUN. Otherwise stay in IDLE.
  - RUN: exactly WIDTH cycles, one iteration per cycle. After the WIDTH-th iteration, go to DONE.
  - DONE: one cycle; res updated, finish=1. Then return to IDLE.
- Latency: start sampled at edge 0 -> busy=1 for cycles 1..WIDTH+1 -> finish=1 in cycle WIDTH+1. Earliest next accept is at the end of cycle WIDTH+2.
- start while busy (RUN or DONE) is ignored. Input changes after acceptance have no effect on the running operation.
- If start is held high continuously, operations issue back-to-back, one every WIDTH+2 cycles.
- res and div_by_zero change only in the DONE cycle (and at reset). They hold between operations.
- Unsigned multiply: shift-add. Each cycle, add the multiplicand if the current multiplier LSB is 1, then shift. Accumulator is 2*WIDTH bits; no overflow is possible.
- Signed multiply:
  - Take the magnitudes of a and b (WIDTH-bit unsigned; the most-negative value maps correctly as an unsigned magnitude).
  - Run the unsigned multiply.
  - Two's-complement negate the 2*WIDTH product if a[WIDTH-1] XOR b[WIDTH-1].
  - The result is always representable; no saturation.
- Unsigned divide:
  - Restoring division, WIDTH iterations: shift the remainder left by one, bring in the next dividend bit, trial-subtract b.
  - Quotient goes to res[WIDTH-1:0], remainder to res[2*WIDTH-1:WIDTH].
- Divide by zero: the full WIDTH-cycle latency is still taken. Quotient=all ones, remainder=a, div_by_zero=1 (asserted with finish, held until the next accepted start).
- Mode 11: identical to 00 in every respect.
- Reset mid-operation aborts with no finish pulse. Outputs return to their reset values. The next start after reset is accepted normally.

Decomposition:
- Shared package: mode constants (MODE_UMUL, MODE_SMUL, MODE_UDIV) and the state encoding (IDLE, RUN, DONE).
- One natural sub-module, muldiv_step: combinational single-iteration datapath (shift-add or restoring-subtract step) selected by the latched mode.
- The FSM, counter, sign fix-up and output registers stay in iter_muldiv.

Test Plan:
1. WIDTH=4, mode=00, a=13, b=11, 1-cycle start -> busy high for exactly cycles 1..5, finish pulses only in cycle 5, res=8'h8F (143).
2. mode=01: a=4'b1000 (-8), b=4'b1001 (-7) -> res=8'h38 (56); a=4'b1101 (-3), b=5 -> res=8'hF1 (-15); a=-8, b=-8 -> res=8'h40.
3. mode=10: a=13, b=4 -> res=8'h13 (r=1, q=3), div_by_zero=0; a=9, b=0 -> res=8'h9F, div_by_zero=1 with finish; next umul clears div_by_zero.
4. start held high, operands changed every cycle while busy -> ops accepted only every 6 cycles; each result matches the operands sampled at acceptance; mode=11 result equals the mode=00 result.
5. rst asserted in RUN cycle 2 -> same edge: busy=0, res=0, no finish pulse; start two cycles later with a=2, b=3, mode=00 -> res=8'h06.
6. WIDTH=8, mode=00, a=255, b=255 -> finish in cycle 9, res=16'hFE01; mode=10, a=200, b=7 -> res={8'd4, 8'd28}.
